vx_fpu_rsp_collector: RTL and testbench
=======================================

Name: vx_fpu_rsp_collector

Overview:
- Consumer (slave) end of the FPU response interface. Sits between the FPU core and the writeback/commit stage.
- Accepts lane results, fflags and tag from the FPU and holds them in a small FIFO. Presents one response per cycle to commit.
- Accumulates sticky per-warp fflags (OR over active lanes) for the fcsr. Provides a CSR read/clear port.

Parameters:
- NUM_LANES, 4, lanes per response
- TAG_WIDTH, 8, response tag width; tag[WID_BITS-1:0] is warp id
- NUM_WARPS, 4, warps tracked for sticky fflags; WID_BITS = max(1, clog2(NUM_WARPS))
- XLEN, 32, result width per lane
- DEPTH, 2, FIFO entries (power of 2, >=2)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous reset, active-low (asserted at 0)
- rsp_valid  in  1  FPU response valid
- rsp_result  in  NUM_LANES*XLEN  lane results, lane i at [i*XLEN +: XLEN]
- rsp_fflags  in  NUM_LANES*5  per-lane fflags {NV,DZ,OF,UF,NX}
- rsp_has_fflags  in  1  fflags meaningful for this response
- rsp_tmask  in  NUM_LANES  active-lane mask
- rsp_tag  in  TAG_WIDTH  response tag
- rsp_ready  out  1  collector can accept
- commit_valid  out  1  head entry valid
- commit_result  out  NUM_LANES*XLEN  head results
- commit_tmask  out  NUM_LANES  head mask
- commit_tag  out  TAG_WIDTH  head tag
- commit_ready  in  1  commit stage consumes head
- csr_wid  in  WID_BITS  warp selected for fflags read
- csr_fflags  out  5  sticky fflags of csr_wid (combinational read)
- csr_clear  in  1  clear sticky fflags of csr_wid

Behaviour:
- Reset (async assert, sync release): FIFO empty, count=0, rd/wr ptr=0, all sticky fflags=0. Outputs: rsp_ready=1, commit_valid=0, commit_result/tmask/tag=0.
- Accept = rsp_valid & rsp_ready. Pop = commit_valid & commit_ready.
- rsp_ready = (count != DEPTH), registered from count. No same-cycle pass-through when full: a pop while full does not raise rsp_ready in that cycle.
- Latency: accepted at edge N, commit_valid high after edge N (visible cycle N+1). Strict FIFO order.
- Push and pop in the same cycle: count unchanged, both pointers advance. Pointers wrap modulo DEPTH.
- commit_* holds stable while commit_valid & !commit_ready.
- Sticky fflags update on accept when rsp_has_fflags=1:
  - sticky[wid] |= OR over lanes i with rsp_tmask[i]=1 of rsp_fflags[i].
  - Visible on csr_fflags the cycle after accept.
  - Lanes with tmask=0 never contribute. has_fflags=0 means no update.
- csr_clear: sticky[csr_wid] <= 0. If an update for the same wid happens in the same cycle, the result is the new flags only (clear first, then OR). Different wids are independent.
- wid >= NUM_WARPS (non-power-of-2 config): update ignored; csr_fflags reads 0.
- Reset mid-operation: in-flight entries are discarded, sticky flags are lost, and there is no partial commit.

Optional Feature:
- Macro: VX_FPU_RSP_PERF_EN.
- Defined:
  - Adds outputs perf_rsp_count (32) and perf_stall_count (32), both reset to 0.
  - perf_rsp_count increments on each accept.
  - perf_stall_count increments each cycle with rsp_valid & !rsp_ready.
  - Both wrap at 2^32.
- Undefined: ports and counters are absent. No other behaviour changes.

Test Plan:
- Reset release, then a single response with tag=0x01, tmask=4'b1111, results 1..4, commit_ready=1 -> commit_valid exactly 1 cycle after accept with tag 0x01 and results 1..4. FIFO then empty.
- commit_ready=0 with 3 back-to-back valid responses (tags A,B,C) -> A and B accepted; rsp_ready=0 from the cycle after B. C is accepted only in the cycle after the first pop. Commit order is A,B,C.
- Response wid=2, has_fflags=1, lane0 NX, lane1 OF with tmask=4'b0001 -> csr_fflags(wid=2)=5'b00001 next cycle; wid 0,1,3 stay 0.
- Same response as the previous scenario but has_fflags=0 -> no sticky change.
- sticky[1]=5'b10000; in the same cycle csr_clear with csr_wid=1 and an accept for wid=1 with DZ -> sticky[1]=5'b01000.
- Assert reset with 2 entries queued -> commit_valid=0 and rsp_ready=1 immediately; all sticky flags read 0 after release.

Source files
------------

// File: rtl/vx_fpu_rsp_collector.sv
// vx_fpu_rsp_collector
// Consumer end of the FPU response interface. Responses (lane results, mask,
// tag) are queued in a small FIFO and presented to commit one per cycle.
// Per-warp sticky fflags (OR over active lanes) are kept for the fcsr and
// can be read and cleared through the CSR port.
// Optional: define VX_FPU_RSP_PERF_EN to add accept/stall performance counters.
module vx_fpu_rsp_collector #(
    parameter int NUM_LANES = 4,
    parameter int TAG_WIDTH = 8,
    parameter int NUM_WARPS = 4,
    parameter int XLEN      = 32,
    parameter int DEPTH     = 2,
    localparam int WID_BITS = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      rsp_valid,
    input  logic [NUM_LANES*XLEN-1:0] rsp_result,
    input  logic [NUM_LANES*5-1:0]    rsp_fflags,
    input  logic                      rsp_has_fflags,
    input  logic [NUM_LANES-1:0]      rsp_tmask,
    input  logic [TAG_WIDTH-1:0]      rsp_tag,
    output logic                      rsp_ready,
    output logic                      commit_valid,
    output logic [NUM_LANES*XLEN-1:0] commit_result,
    output logic [NUM_LANES-1:0]      commit_tmask,
    output logic [TAG_WIDTH-1:0]      commit_tag,
    input  logic                      commit_ready,
    input  logic [WID_BITS-1:0]       csr_wid,
    output logic [4:0]                csr_fflags,
    input  logic                      csr_clear
`ifdef VX_FPU_RSP_PERF_EN
    ,
    output logic [31:0]               perf_rsp_count,
    output logic [31:0]               perf_stall_count
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             accept;
    logic             pop;

    logic [NUM_LANES*XLEN-1:0] result_mem [DEPTH];
    logic [NUM_LANES-1:0]      tmask_mem  [DEPTH];
    logic [TAG_WIDTH-1:0]      tag_mem    [DEPTH];

    // Ready comes straight from the registered count, so a pop while full
    // only frees the slot for the following cycle.
    assign rsp_ready    = (count_reg != FULL_CNT);
    assign commit_valid = (count_reg != '0);
    assign accept       = rsp_valid & rsp_ready;
    assign pop          = commit_valid & commit_ready;

    // Pointer and occupancy update; simultaneous push/pop keeps count.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (accept) begin
            wr_ptr_next = wr_ptr_reg + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_W'(1);
        end
        case ({accept, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    // FIFO control registers; reset discards anything in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Payload storage; contents only matter while count says the slot is live.
    always_ff @(posedge clk) begin
        if (accept) begin
            result_mem[wr_ptr_reg] <= rsp_result;
            tmask_mem[wr_ptr_reg]  <= rsp_tmask;
            tag_mem[wr_ptr_reg]    <= rsp_tag;
        end
    end

    // Head is zeroed when empty so stale payload never leaks to commit.
    assign commit_result = commit_valid ? result_mem[rd_ptr_reg] : '0;
    assign commit_tmask  = commit_valid ? tmask_mem[rd_ptr_reg]  : '0;
    assign commit_tag    = commit_valid ? tag_mem[rd_ptr_reg]    : '0;

    // Per-lane fflags masked by the active-lane mask.
    logic [NUM_LANES*5-1:0] lane_flags_masked;
    logic [4:0]             rsp_flags_or;
    logic [WID_BITS-1:0]    upd_wid;
    logic                   upd_en;
    logic [NUM_WARPS*5-1:0] sticky_flat;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            assign lane_flags_masked[gi*5 +: 5] = rsp_tmask[gi] ? rsp_fflags[gi*5 +: 5] : 5'b0;
        end
    endgenerate

    // OR-reduce the active lanes' flags into one 5-bit update.
    always_comb begin
        rsp_flags_or = 5'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            rsp_flags_or = rsp_flags_or | lane_flags_masked[i*5 +: 5];
        end
    end

    assign upd_wid = rsp_tag[WID_BITS-1:0];
    assign upd_en  = accept & rsp_has_fflags;

    generate
        for (gi = 0; gi < NUM_WARPS; gi++) begin : g_warp
            logic [4:0] sticky_reg, sticky_next;
            logic       hit;
            logic       clr;

            assign hit = upd_en && (upd_wid == WID_BITS'(gi));
            assign clr = csr_clear && (csr_wid == WID_BITS'(gi));

            // Clear takes effect before a same-cycle update is OR-ed in.
            always_comb begin
                sticky_next = sticky_reg;
                if (clr) begin
                    sticky_next = 5'b0;
                end
                if (hit) begin
                    sticky_next = sticky_next | rsp_flags_or;
                end
            end

            // Sticky flag register for this warp.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    sticky_reg <= 5'b0;
                end else begin
                    sticky_reg <= sticky_next;
                end
            end

            assign sticky_flat[gi*5 +: 5] = sticky_reg;
        end
    endgenerate

    // Combinational CSR read; a wid with no tracked warp reads as zero.
    always_comb begin
        csr_fflags = 5'b0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            if (csr_wid == WID_BITS'(i)) begin
                csr_fflags = sticky_flat[i*5 +: 5];
            end
        end
    end

`ifdef VX_FPU_RSP_PERF_EN
    logic [31:0] perf_rsp_count_reg;
    logic [31:0] perf_stall_count_reg;

    // Free-running accept and back-pressure counters, wrapping at 2^32.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_rsp_count_reg   <= '0;
            perf_stall_count_reg <= '0;
        end else begin
            if (accept) begin
                perf_rsp_count_reg <= perf_rsp_count_reg + 32'd1;
            end
            if (rsp_valid && !rsp_ready) begin
                perf_stall_count_reg <= perf_stall_count_reg + 32'd1;
            end
        end
    end

    assign perf_rsp_count   = perf_rsp_count_reg;
    assign perf_stall_count = perf_stall_count_reg;
`endif

endmodule

// File: tb/tb_vx_fpu_rsp_collector.sv
// Testbench for vx_fpu_rsp_collector: directed scenarios followed by random
// traffic, checked by a scoreboard monitor against a queue/array model.
module tb_vx_fpu_rsp_collector;

    localparam int NUM_LANES = 4;
    localparam int TAG_WIDTH = 8;
    localparam int NUM_WARPS = 4;
    localparam int XLEN      = 32;
    localparam int DEPTH     = 2;
    localparam int WID_BITS  = 2;
    localparam int RW        = NUM_LANES * XLEN;

    typedef struct {
        logic [TAG_WIDTH-1:0] tag;
        logic [NUM_LANES-1:0] tmask;
        logic [RW-1:0]        result;
    } rsp_t;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic                   rsp_valid = 1'b0;
    logic [RW-1:0]          rsp_result = '0;
    logic [NUM_LANES*5-1:0] rsp_fflags = '0;
    logic                   rsp_has_fflags = 1'b0;
    logic [NUM_LANES-1:0]   rsp_tmask = '0;
    logic [TAG_WIDTH-1:0]   rsp_tag = '0;
    logic                   rsp_ready;
    logic                   commit_valid;
    logic [RW-1:0]          commit_result;
    logic [NUM_LANES-1:0]   commit_tmask;
    logic [TAG_WIDTH-1:0]   commit_tag;
    logic                   commit_ready = 1'b0;
    logic [WID_BITS-1:0]    csr_wid = '0;
    logic [4:0]             csr_fflags;
    logic                   csr_clear = 1'b0;
`ifdef VX_FPU_RSP_PERF_EN
    logic [31:0]            perf_rsp_count;
    logic [31:0]            perf_stall_count;
    int unsigned            model_acc = 0;
    int unsigned            model_stall = 0;
`endif

    rsp_t       exp_q[$];
    logic [4:0] sticky_model [NUM_WARPS];
    int         checks = 0;
    int         errors = 0;
    bit         rand_mode = 1'b0;

    vx_fpu_rsp_collector #(
        .NUM_LANES(NUM_LANES), .TAG_WIDTH(TAG_WIDTH), .NUM_WARPS(NUM_WARPS),
        .XLEN(XLEN), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_fflags(rsp_fflags),
        .rsp_has_fflags(rsp_has_fflags), .rsp_tmask(rsp_tmask), .rsp_tag(rsp_tag),
        .rsp_ready(rsp_ready),
        .commit_valid(commit_valid), .commit_result(commit_result),
        .commit_tmask(commit_tmask), .commit_tag(commit_tag), .commit_ready(commit_ready),
        .csr_wid(csr_wid), .csr_fflags(csr_fflags), .csr_clear(csr_clear)
`ifdef VX_FPU_RSP_PERF_EN
        , .perf_rsp_count(perf_rsp_count), .perf_stall_count(perf_stall_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: compares at the falling edge, then updates the model
    // with whatever the upcoming rising edge will do.
    initial begin
        for (int w = 0; w < NUM_WARPS; w++) sticky_model[w] = 5'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                exp_q.delete();
                for (int w = 0; w < NUM_WARPS; w++) sticky_model[w] = 5'b0;
                check("rst_commit_valid", RW'(commit_valid), RW'(1'b0));
                check("rst_rsp_ready", RW'(rsp_ready), RW'(1'b1));
                check("rst_commit_tag", RW'(commit_tag), RW'(0));
                check("rst_csr_fflags", RW'(csr_fflags), RW'(0));
            end else begin
                check("rsp_ready", RW'(rsp_ready), RW'(exp_q.size() != DEPTH));
                check("commit_valid", RW'(commit_valid), RW'(exp_q.size() != 0));
                check("csr_fflags", RW'(csr_fflags), RW'(sticky_model[csr_wid]));
                if (commit_valid && exp_q.size() > 0) begin
                    check("commit_tag", RW'(commit_tag), RW'(exp_q[0].tag));
                    check("commit_tmask", RW'(commit_tmask), RW'(exp_q[0].tmask));
                    check("commit_result", commit_result, exp_q[0].result);
                    if (commit_ready) begin
                        $display("commit tag=%02h tmask=%b result=%032h", commit_tag, commit_tmask, commit_result);
                        void'(exp_q.pop_front());
                    end
                end
            end
            #1;
            if (reset) begin
                if (rsp_valid && rsp_ready) begin
                    rsp_t r;
                    r.tag = rsp_tag;
                    r.tmask = rsp_tmask;
                    r.result = rsp_result;
                    exp_q.push_back(r);
                end
                if (csr_clear) sticky_model[csr_wid] = 5'b0;
                if (rsp_valid && rsp_ready && rsp_has_fflags) begin
                    for (int l = 0; l < NUM_LANES; l++)
                        if (rsp_tmask[l]) sticky_model[rsp_tag[WID_BITS-1:0]] |= rsp_fflags[l*5 +: 5];
                end
`ifdef VX_FPU_RSP_PERF_EN
                if (rsp_valid && rsp_ready) model_acc++;
                if (rsp_valid && !rsp_ready) model_stall++;
            end else begin
                model_acc = 0;
                model_stall = 0;
`endif
            end
        end
    end

    // Background randomisation of commit back-pressure and CSR traffic.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_mode) begin
                commit_ready = ($urandom_range(0, 3) != 0);
                csr_wid      = WID_BITS'($urandom);
                csr_clear    = ($urandom_range(0, 7) == 0);
            end
        end
    end

    // Drive one response and hold it until accepted (bounded wait).
    // Called and returns at one time unit after a rising edge.
    task automatic send(input logic [TAG_WIDTH-1:0] tag, input logic [NUM_LANES-1:0] tmask,
                        input logic [RW-1:0] result, input logic [NUM_LANES*5-1:0] ff,
                        input logic has_ff);
        bit acc = 1'b0;
        int n = 0;
        rsp_valid = 1'b1;
        rsp_tag = tag;
        rsp_tmask = tmask;
        rsp_result = result;
        rsp_fflags = ff;
        rsp_has_fflags = has_ff;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = rsp_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: tag %0h not accepted within %0d cycles", tag, n);
        end
        rsp_valid = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        tick(3);
        reset = 1'b1;
        tick(1);

        // Single response with immediate commit.
        commit_ready = 1'b1;
        send(8'h01, 4'b1111, {32'd4, 32'd3, 32'd2, 32'd1}, '0, 1'b0);
        check("s1_valid", RW'(commit_valid), RW'(1'b1));
        check("s1_tag", RW'(commit_tag), RW'(8'h01));
        check("s1_result", commit_result, {32'd4, 32'd3, 32'd2, 32'd1});
        tick(1);
        check("s1_empty", RW'(commit_valid), RW'(1'b0));

        // Back-pressure: two fill the FIFO, the third waits for a pop.
        commit_ready = 1'b0;
        send(8'h0A, 4'b1010, RW'(128'hA), '0, 1'b0);
        send(8'h0B, 4'b0101, RW'(128'hB), '0, 1'b0);
        check("s2_full_ready", RW'(rsp_ready), RW'(1'b0));
        fork
            send(8'h0C, 4'b1111, RW'(128'hC), '0, 1'b0);
            begin
                tick(3);
                commit_ready = 1'b1;
            end
        join
        tick(3);
        check("s2_drained", RW'(commit_valid), RW'(1'b0));

        // Masked fflags: lane0 NX active, lane1 OF masked off.
        send(8'h02, 4'b0001, RW'(128'h55), {5'b0, 5'b0, 5'b00100, 5'b00001}, 1'b1);
        for (int w = 0; w < NUM_WARPS; w++) begin
            csr_wid = WID_BITS'(w);
            tick(1);
            check("s3_sticky", RW'(csr_fflags), RW'((w == 2) ? 5'b00001 : 5'b00000));
        end

        // has_fflags=0 leaves the sticky state alone.
        send(8'h02, 4'b0011, RW'(128'h66), {5'b0, 5'b0, 5'b00100, 5'b00001}, 1'b0);
        csr_wid = 2'd2;
        tick(1);
        check("s4_no_update", RW'(csr_fflags), RW'(5'b00001));

        // Clear and update of the same warp in one cycle: new flags only.
        send(8'h01, 4'b0001, RW'(128'h77), {15'b0, 5'b10000}, 1'b1);
        csr_wid = 2'd1;
        tick(1);
        check("s5_pre", RW'(csr_fflags), RW'(5'b10000));
        csr_clear = 1'b1;
        send(8'h01, 4'b0001, RW'(128'h88), {15'b0, 5'b01000}, 1'b1);
        csr_clear = 1'b0;
        check("s5_clear_then_or", RW'(csr_fflags), RW'(5'b01000));
        tick(2);

        // Reset with two entries queued.
        commit_ready = 1'b0;
        send(8'h11, 4'b1111, RW'(128'h1111), '0, 1'b0);
        send(8'h12, 4'b1111, RW'(128'h1212), '0, 1'b0);
        reset = 1'b0;
        #1;
        check("s6_rst_valid", RW'(commit_valid), RW'(1'b0));
        check("s6_rst_ready", RW'(rsp_ready), RW'(1'b1));
        tick(2);
        reset = 1'b1;
        for (int w = 0; w < NUM_WARPS; w++) begin
            csr_wid = WID_BITS'(w);
            tick(1);
            check("s6_sticky_cleared", RW'(csr_fflags), RW'(0));
        end

        // Random traffic against the scoreboard.
        rand_mode = 1'b1;
        for (int t = 0; t < 400; t++) begin
            if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 3));
            send(TAG_WIDTH'($urandom), NUM_LANES'($urandom),
                 {$urandom, $urandom, $urandom, $urandom},
                 (NUM_LANES*5)'({$urandom}), 1'($urandom));
        end
        rand_mode = 1'b0;
        tick(1);
        commit_ready = 1'b1;
        csr_clear = 1'b0;
        tick(10);
        check("final_empty", RW'(commit_valid), RW'(1'b0));
        check("final_queue", RW'(exp_q.size()), RW'(0));
`ifdef VX_FPU_RSP_PERF_EN
        check("perf_rsp_count", RW'(perf_rsp_count), RW'(model_acc));
        check("perf_stall_count", RW'(perf_stall_count), RW'(model_stall));
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
